// File: rtl/incr_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : incr_checker_pkg
//  Function : Shared state encoding, limits and golden-value helper for the
//             increment-stream checker.
//  Revision : 1.0
// ============================================================================
package incr_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int MAX_LAT = 8;
    localparam int MAX_W   = 128;

    // Untruncated successor; the caller truncates to its lane width, which yields the wrap.
    function automatic logic [MAX_W-1:0] golden_incr(input logic [MAX_W-1:0] data,
                                                     input logic             rst_l);
        return rst_l ? data + 1'b1 : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/incr_stream_checker_delay.sv
`default_nettype none
// ============================================================================
//  Module   : incr_delay_line
//  Function : LAT-deep shift register for {valid, rst_l, data}; flush clears
//             every valid bit on the same edge.
//  Revision : 1.0
// ============================================================================
module incr_delay_line #(
    parameter int LAT   = 1,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             rst_l_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             rst_l_o,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (LAT == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{clk, reset};
            assign valid_o  = valid_i & ~flush_i;
            assign rst_l_o  = rst_l_i;
            assign data_o   = data_i;
        end else begin : g_pipe
            logic [LAT-1:0]            valid_q;
            logic [LAT-1:0]            rst_l_q;
            logic [LAT-1:0][WIDTH-1:0] data_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= '0;
                    rst_l_q <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q[0] <= valid_i & ~flush_i;
                    rst_l_q[0] <= rst_l_i;
                    data_q[0]  <= data_i;
                    for (int i = 1; i < LAT; i++) begin
                        valid_q[i] <= valid_q[i-1] & ~flush_i;
                        rst_l_q[i] <= rst_l_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[LAT-1];
            assign rst_l_o = rst_l_q[LAT-1];
            assign data_o  = data_q[LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/incr_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module   : incr_stream_checker
//  Function : Compares a lane's output against stimulus+1 (or 0 in DUT reset),
//             counting matches/errors and holding the first failing pair.
//  Revision : 1.0
// ============================================================================
module incr_stream_checker
    import incr_checker_pkg::*;
#(
    parameter int WIDTH       = 40,
    parameter int LAT         = 1,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] stim_data,
    input  logic             dut_rst_l,
    input  logic [WIDTH-1:0] dut_data,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic [1:0]       state
);

    localparam int FILL_W = $clog2(MAX_LAT + 1);

    state_e              state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    match_q, match_d, err_q, err_d;
    logic                fev_q, fev_d;
    logic [WIDTH-1:0]    exp_q, exp_d, got_q, got_d;

    logic                w_dl_valid, w_dl_rst_l;
    logic [WIDTH-1:0]    w_dl_data, w_exp;
    logic                w_mismatch, w_do_cmp;

    incr_delay_line #(
        .LAT   (LAT),
        .WIDTH (WIDTH)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .flush_i (~enable),
        .valid_i (stim_valid),
        .rst_l_i (dut_rst_l),
        .data_i  (stim_data),
        .valid_o (w_dl_valid),
        .rst_l_o (w_dl_rst_l),
        .data_o  (w_dl_data)
    );

    assign w_exp      = WIDTH'(golden_incr(MAX_W'(w_dl_data), w_dl_rst_l));
    assign w_mismatch = (w_exp != dut_data);

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        w_do_cmp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (LAT == 0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_FILL;
                        fill_d  = FILL_W'(LAT);
                    end
                end
            end
            ST_FILL: begin
                fill_d = fill_q - 1'b1;
                if (fill_q == FILL_W'(1)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_dl_valid) begin
                    w_do_cmp = ~clear;
                    if (w_mismatch && STOP_ON_ERR && !clear) state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d  = ST_IDLE;
            w_do_cmp = 1'b0;
        end
    end

    always_comb begin
        match_d = match_q;
        err_d   = err_q;
        fev_d   = fev_q;
        exp_d   = exp_q;
        got_d   = got_q;
        if (clear) begin
            match_d = '0;
            err_d   = '0;
            fev_d   = 1'b0;
            exp_d   = '0;
            got_d   = '0;
        end else if (w_do_cmp) begin
            if (w_mismatch) begin
                if (err_q != '1) err_d = err_q + 1'b1;
                if (!fev_q) begin
                    fev_d = 1'b1;
                    exp_d = w_exp;
                    got_d = dut_data;
                end
            end else if (match_q != '1) begin
                match_d = match_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            match_q <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            exp_q   <= '0;
            got_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            exp_q   <= exp_d;
            got_q   <= got_d;
        end
    end

    assign match_count     = match_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_exp   = exp_q;
    assign first_err_got   = got_q;
    assign state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_incr_stream_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_incr_stream_checker
//  Function : Three checker lanes (LAT 1/3/0) against a cycle-level model.
//  Revision : 1.0
// ============================================================================
module tb_incr_stream_checker;

    localparam int NL = 3;
    localparam logic [63:0] W40 = 64'h0000_00FF_FFFF_FFFF;

    typedef struct packed {
        logic        v;
        logic        rl;
        logic [63:0] d;
    } smp_t;

    logic        clk;
    logic        reset, enable, clear, stim_valid, dut_rst_l;
    logic [39:0] stim_data, d0, d1;
    logic [1:0]  d2;

    logic [15:0] m0_match, m0_err;  logic m0_fev;  logic [39:0] m0_exp, m0_got;  logic [1:0] m0_state;
    logic [3:0]  m1_match, m1_err;  logic m1_fev;  logic [39:0] m1_exp, m1_got;  logic [1:0] m1_state;
    logic [15:0] m2_match, m2_err;  logic m2_fev;  logic [1:0]  m2_exp, m2_got;  logic [1:0] m2_state;

    logic [63:0] v_match[NL], v_err[NL], v_fev[NL], v_exp[NL], v_got[NL], v_state[NL];

    int          checks, errors, cyc;
    logic [63:0] h_stim[16], h_mask[16];
    logic        h_rl[16];
    smp_t        hist[$];
    int          k[NL];
    bit          halted[NL];
    logic [63:0] m_match[NL], m_err[NL], m_fev[NL], m_exp[NL], m_got[NL];

    incr_stream_checker #(.WIDTH(40), .LAT(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stim_valid(stim_valid),
        .stim_data(stim_data), .dut_rst_l(dut_rst_l), .dut_data(d0),
        .match_count(m0_match), .err_count(m0_err), .first_err_valid(m0_fev),
        .first_err_exp(m0_exp), .first_err_got(m0_got), .state(m0_state));

    incr_stream_checker #(.WIDTH(40), .LAT(3), .CNT_W(4), .STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stim_valid(stim_valid),
        .stim_data(stim_data), .dut_rst_l(dut_rst_l), .dut_data(d1),
        .match_count(m1_match), .err_count(m1_err), .first_err_valid(m1_fev),
        .first_err_exp(m1_exp), .first_err_got(m1_got), .state(m1_state));

    incr_stream_checker #(.WIDTH(2), .LAT(0), .CNT_W(16), .STOP_ON_ERR(1'b0)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .stim_valid(stim_valid),
        .stim_data(stim_data[1:0]), .dut_rst_l(dut_rst_l), .dut_data(d2),
        .match_count(m2_match), .err_count(m2_err), .first_err_valid(m2_fev),
        .first_err_exp(m2_exp), .first_err_got(m2_got), .state(m2_state));

    assign v_match[0] = 64'(m0_match); assign v_err[0] = 64'(m0_err); assign v_fev[0] = 64'(m0_fev);
    assign v_exp[0]   = 64'(m0_exp);   assign v_got[0] = 64'(m0_got); assign v_state[0] = 64'(m0_state);
    assign v_match[1] = 64'(m1_match); assign v_err[1] = 64'(m1_err); assign v_fev[1] = 64'(m1_fev);
    assign v_exp[1]   = 64'(m1_exp);   assign v_got[1] = 64'(m1_got); assign v_state[1] = 64'(m1_state);
    assign v_match[2] = 64'(m2_match); assign v_err[2] = 64'(m2_err); assign v_fev[2] = 64'(m2_fev);
    assign v_exp[2]   = 64'(m2_exp);   assign v_got[2] = 64'(m2_got); assign v_state[2] = 64'(m2_state);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int l);
        return (l == 0) ? 1 : (l == 1) ? 3 : 0;
    endfunction
    function automatic logic [63:0] wmask(input int l);
        return (l == 2) ? 64'h3 : W40;
    endfunction
    function automatic logic [63:0] cmax(input int l);
        return (l == 1) ? 64'd15 : 64'd65535;
    endfunction
    function automatic logic [63:0] lane_in(input int l);
        return (l == 0) ? 64'(d0) : (l == 1) ? 64'(d1) : 64'(d2);
    endfunction
    function automatic logic [63:0] exp_state(input int l);
        if (halted[l])           return 64'd3;
        if (k[l] == 0)           return 64'd0;
        if (k[l] <= lat_of(l))   return 64'd1;
        return 64'd2;
    endfunction
    // Value the bench's stand-in DUT presents now: successor of the word LAT cycles ago, xor an injected error.
    function automatic logic [63:0] drive_val(input int l);
        int          idx;
        logic [63:0] g;
        idx = (cyc - lat_of(l)) & 15;
        g   = h_rl[idx] ? h_stim[idx] + 64'd1 : 64'd0;
        return (g ^ h_mask[idx]) & wmask(l);
    endfunction

    task automatic chk(input string nm, input int l, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane%0d got=%0h expected=%0h (t=%0t)", nm, l, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        hist.delete();
        for (int l = 0; l < NL; l++) begin
            k[l] = 0; halted[l] = 1'b0;
            m_match[l] = '0; m_err[l] = '0; m_fev[l] = '0; m_exp[l] = '0; m_got[l] = '0;
        end
    endtask

    task automatic model_edge();
        smp_t s;
        s.v = stim_valid; s.rl = dut_rst_l; s.d = 64'(stim_data);
        hist.push_front(s);
        if (hist.size() > 16) void'(hist.pop_back());
        for (int l = 0; l < NL; l++) begin
            int          lat;
            bit          cmp, to_idle;
            logic [63:0] e, g;
            lat     = lat_of(l);
            to_idle = !enable || (clear && halted[l]);
            cmp     = 1'b0;
            e       = '0;
            if (enable && !halted[l] && k[l] > lat && hist.size() > lat) begin
                cmp = hist[lat].v;
                e   = (hist[lat].rl ? hist[lat].d + 64'd1 : 64'd0) & wmask(l);
            end
            g = lane_in(l);
            if (clear) begin
                m_match[l] = '0; m_err[l] = '0; m_fev[l] = '0; m_exp[l] = '0; m_got[l] = '0;
            end else if (cmp) begin
                if (e != g) begin
                    if (m_err[l] < cmax(l)) m_err[l] = m_err[l] + 64'd1;
                    if (m_fev[l] == 0) begin
                        m_fev[l] = 64'd1; m_exp[l] = e; m_got[l] = g;
                    end
                    if (l == 1) halted[l] = 1'b1;
                end else if (m_match[l] < cmax(l)) begin
                    m_match[l] = m_match[l] + 64'd1;
                end
            end
            if (to_idle) begin
                k[l] = 0; halted[l] = 1'b0;
            end else if (!halted[l] && k[l] < 1000) begin
                k[l] = k[l] + 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic rl, input logic [63:0] d, input logic [63:0] m,
                        input logic en, input logic clr);
        cyc++;
        h_stim[cyc & 15] = d & W40;
        h_rl[cyc & 15]   = rl;
        h_mask[cyc & 15] = m;
        stim_valid = v; dut_rst_l = rl; stim_data = d[39:0]; enable = en; clear = clr;
        d0 = 40'(drive_val(0));
        d1 = 40'(drive_val(1));
        d2 = 2'(drive_val(2));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0);
    endtask

    // Per-cycle comparison of every lane against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int l = 0; l < NL; l++) begin
                    chk("match_count", l, v_match[l], m_match[l]);
                    chk("err_count", l, v_err[l], m_err[l]);
                    chk("first_err_valid", l, v_fev[l], m_fev[l]);
                    chk("first_err_exp", l, v_exp[l], m_exp[l]);
                    chk("first_err_got", l, v_got[l], m_got[l]);
                    chk("state", l, v_state[l], exp_state(l));
                end
            end
        end
    end

    initial begin
        logic [63:0] r;
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin h_stim[i] = '0; h_mask[i] = '0; h_rl[i] = 1'b1; end
        reset = 1'b1; enable = 1'b0; clear = 1'b0; stim_valid = 1'b0; dut_rst_l = 1'b1;
        stim_data = '0; d0 = '0; d1 = '0; d2 = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int l = 0; l < NL; l++) begin
            chk("lit_reset_state", l, v_state[l], 64'd0);
            chk("lit_reset_match", l, v_match[l], 64'd0);
        end

        idle(5);
        step(1, 1, 64'h5, 0, 1, 0);
        step(1, 1, 64'hFF, 0, 1, 0);
        idle(4);
        chk("lit_basic_match", 0, v_match[0], 64'd2);
        chk("lit_basic_err", 0, v_err[0], 64'd0);
        chk("lit_basic_match", 1, v_match[1], 64'd2);

        step(1, 1, 64'hFF_FFFF_FFFF, 0, 1, 0);
        step(1, 0, 64'h123, 0, 1, 0);
        step(1, 0, 64'h123, 64'h124, 1, 0);
        idle(4);
        chk("lit_wrap_match", 0, v_match[0], 64'd4);
        chk("lit_rst_err", 0, v_err[0], 64'd1);
        chk("lit_rst_exp", 0, v_exp[0], 64'd0);
        chk("lit_rst_got", 0, v_got[0], 64'h124);
        chk("lit_halt_state", 1, v_state[1], 64'd3);

        step(0, 1, 0, 0, 1, 1);
        chk("lit_clear_state", 1, v_state[1], 64'd0);
        chk("lit_clear_err", 0, v_err[0], 64'd0);
        chk("lit_clear_fev", 0, v_fev[0], 64'd0);

        idle(5);
        step(1, 1, 64'h10, 64'h03, 1, 0);
        idle(4);
        chk("lit_stop_err", 1, v_err[1], 64'd1);
        chk("lit_stop_exp", 1, v_exp[1], 64'h11);
        chk("lit_stop_got", 1, v_got[1], 64'h12);
        chk("lit_stop_state", 1, v_state[1], 64'd3);
        repeat (3) step(1, 1, 64'h7, 0, 1, 0);
        idle(4);
        chk("lit_frozen_match", 1, v_match[1], 64'd0);
        chk("lit_frozen_err", 1, v_err[1], 64'd1);

        step(1, 1, 64'h20, 64'h11, 1, 0);
        idle(2);
        chk("lit_two_err", 0, v_err[0], 64'd2);
        chk("lit_two_exp", 0, v_exp[0], 64'h11);
        chk("lit_two_got", 0, v_got[0], 64'h12);
        step(1, 1, 64'h30, 64'h05, 1, 0);
        step(0, 1, 0, 0, 1, 1);
        chk("lit_clrcmp_err", 0, v_err[0], 64'd0);
        chk("lit_clrcmp_fev", 0, v_fev[0], 64'd0);

        idle(5);
        repeat (20) begin
            r = {32'($urandom), 32'($urandom)};
            step(1, 1, r, 0, 1, 0);
        end
        idle(4);
        chk("lit_sat_match", 1, v_match[1], 64'd15);
        chk("lit_run_match", 0, v_match[0], 64'd20);

        step(1, 1, 64'h1, 0, 1, 0);
        step(1, 1, 64'h2, 0, 0, 0);
        chk("lit_drop_state", 1, v_state[1], 64'd0);
        step(1, 1, 64'h3, 0, 1, 0);
        chk("lit_fill_state", 1, v_state[1], 64'd1);
        chk("lit_fill_state", 0, v_state[0], 64'd1);
        step(1, 1, 64'h4, 0, 1, 0);
        step(1, 1, 64'h5, 0, 1, 0);
        idle(3);
        chk("lit_drop_match", 0, v_match[0], 64'd22);

        for (int i = 0; i < 1500; i++) begin
            logic        v, rl, en, clr;
            logic [63:0] d, m;
            v   = ($urandom % 10) < 7;
            rl  = ($urandom % 8) != 0;
            d   = (($urandom % 16) == 0) ? W40 : {32'($urandom), 32'($urandom)};
            m   = (($urandom % 10) == 0) ? 64'(1 + $urandom % 255) : 64'd0;
            en  = ($urandom % 60) != 0;
            clr = ($urandom % 50) == 0;
            step(v, rl, d, m, en, clr);
        end

        idle(6);
        step(1, 1, 64'h40, 0, 1, 0);
        #2 reset = 1'b1;
        reset_model();
        #1;
        for (int l = 0; l < NL; l++) begin
            chk("lit_async_state", l, v_state[l], 64'd0);
            chk("lit_async_match", l, v_match[l], 64'd0);
            chk("lit_async_err", l, v_err[l], 64'd0);
            chk("lit_async_fev", l, v_fev[l], 64'd0);
            chk("lit_async_exp", l, v_exp[l], 64'd0);
            chk("lit_async_got", l, v_got[l], 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/incr_stream_checker.md
Name: incr_stream_checker

Overview:
- Scoreboard stage directly downstream of the simulation top's increment datapath.
- Consumes the stimulus word driven into the top and the word the top drives out, then checks each output against its golden value:
  - input + 1, modulo 2^WIDTH;
  - forced to zero while the top's reset is asserted.
- Counts matches and mismatches, captures the first failing pair, and can halt checking on the first error.
- One instance per data lane (small/quad/wide) in the verification harness.

Parameters:
- WIDTH, 40, data width of the checked lane (2, 40 or 70 in use).
- LAT, 1, DUT latency in clk cycles between stimulus and result; legal range 0..8.
- CNT_W, 16, width of the saturating match/error counters.
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch.

Ports:
- clk  input  1  sole clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; checking runs while high.
- clear  input  1  single-cycle pulse; zeroes counters and capture, leaves HALT.
- stim_valid  input  1  stim_data and dut_rst_l are meaningful this cycle.
- stim_data  input  WIDTH  word driven into the DUT lane.
- dut_rst_l  input  1  the DUT's active-low reset, as applied with the stimulus.
- dut_data  input  WIDTH  DUT lane output.
- match_count  output  CNT_W  saturating count of passing compares.
- err_count  output  CNT_W  saturating count of failing compares.
- first_err_valid  output  1  a first-error capture is held.
- first_err_exp  output  WIDTH  expected value of the first failing compare.
- first_err_got  output  WIDTH  observed value of the first failing compare.
- state  output  2  FSM state: 0 IDLE, 1 FILL, 2 CHECK, 3 HALT.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, delay-line valid bits 0.
- Delay line:
  - LAT stages shift {stim_valid, dut_rst_l, stim_data} every cycle, regardless of state.
  - With LAT=0 the compare is combinational-aligned (same cycle).
- Golden value: exp = (~dut_rst_l_d) ? 0 : (stim_data_d + 1) truncated to WIDTH bits. All-ones wraps to 0.
- FSM:
  - IDLE -> FILL when enable=1; the fill counter loads LAT.
  - FILL: decrement the counter each cycle; -> CHECK when it reaches 0. LAT=0 goes IDLE -> CHECK directly. Stale stages are never compared.
  - CHECK: compare when the delayed valid = 1. On a mismatch with STOP_ON_ERR=1 -> HALT (the mismatch itself is counted).
  - HALT: no compares; counters frozen. -> IDLE on clear.
  - Any state -> IDLE when enable=0; delay-line valid bits flush to 0 the same cycle. Counters and capture are retained.
- Counters:
  - +1 per compare.
  - Saturate at 2^CNT_W-1; no wrap.
- First-error capture:
  - Loads exp/got and sets first_err_valid on the first mismatch only.
  - Later mismatches do not overwrite it.
- Output timing: counter and capture updates are registered and visible the cycle after the compare.
- clear:
  - Zeroes counters and capture.
  - Priority over a same-cycle compare: that compare is discarded, not counted.
  - In HALT -> IDLE; in other states the state is unchanged.
- enable=0 and clear in the same cycle: both take effect.
- Reset mid-CHECK: immediate return to IDLE with all outputs zeroed; no partial count update.
- stim_valid=0 cycles produce no compare and no count change.

Decomposition:
- Package incr_checker_pkg holds:
  - state enum (IDLE, FILL, CHECK, HALT) with 2-bit encoding;
  - MAX_LAT=8 constant;
  - a function computing the golden increment with reset masking.
- One natural sub-module: incr_delay_line, a parameterised LAT-deep shift register carrying valid, rst_l and data, with a flush input.

Test Plan:
- Reset while enable=1 and data flowing -> all outputs 0, state=0 the same cycle reset asserts.
- LAT=1, WIDTH=40; drive stim 0x0000000005 then 0x00000000FF with dut_data one cycle later 0x06, 0x100 -> match_count=2, err_count=0.
- Wrap: stim 0xFFFFFFFFFF, dut 0x0000000000 -> match. Then dut_rst_l=0 with stim 0x123 and dut 0 -> match; same with dut 0x124 -> error, exp=0, got=0x124.
- STOP_ON_ERR=1: stim 0x10, dut 0x12 -> err_count=1, first_err_exp=0x11, first_err_got=0x12, state=HALT. Further stimulus leaves counts frozen; clear -> counts 0, state IDLE.
- Two mismatches (exp 0x11/got 0x12, then exp 0x21/got 0x30) -> capture holds 0x11/0x12, err_count=2. Clear asserted on the cycle of a third mismatch -> err_count=0, first_err_valid=0.
- CNT_W=4, 20 matching words -> match_count stays 15. enable dropped for one cycle mid-stream -> FILL for LAT cycles; words in flight at the drop are not compared.
